// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module  : multicycle_pkg
// Brief   : Shared types for the RV64I multi-cycle controller and decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  typedef enum logic [1:0] {
    PC_PLUS4   = 2'd0,
    PC_IMM     = 2'd1,
    PC_RS1_IMM = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [3:0] {
    CL_OP       = 4'd0,
    CL_OP_IMM   = 4'd1,
    CL_OP_32    = 4'd2,
    CL_OP_IMM32 = 4'd3,
    CL_LOAD     = 4'd4,
    CL_STORE    = 4'd5,
    CL_BRANCH   = 4'd6,
    CL_JAL      = 4'd7,
    CL_JALR     = 4'd8,
    CL_LUI      = 4'd9,
    CL_AUIPC    = 4'd10,
    CL_ILLEGAL  = 4'd11
  } iclass_t;

  // Register-register and branch classes feed rs2 into the ALU; all others use the immediate.
  function automatic logic uses_imm(input iclass_t c);
    case (c)
      CL_OP, CL_OP_32, CL_BRANCH, CL_ILLEGAL: uses_imm = 1'b0;
      default:                                uses_imm = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_opcode_decoder.sv
// ============================================================================
// Module  : opcode_decoder
// Brief   : Combinational RV64I major-opcode classifier (class + legal bit).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module opcode_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = CL_ILLEGAL;
    legal  = 1'b1;
    case (opcode)
      OPC_OP:        iclass = CL_OP;
      OPC_OP_IMM:    iclass = CL_OP_IMM;
      OPC_OP_32:     iclass = CL_OP_32;
      OPC_OP_IMM_32: iclass = CL_OP_IMM32;
      OPC_LOAD:      iclass = CL_LOAD;
      OPC_STORE:     iclass = CL_STORE;
      OPC_BRANCH:    iclass = CL_BRANCH;
      OPC_JAL:       iclass = CL_JAL;
      OPC_JALR:      iclass = CL_JALR;
      OPC_LUI:       iclass = CL_LUI;
      OPC_AUIPC:     iclass = CL_AUIPC;
      default:       legal  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout.
//           MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes halt and set illegal_instr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  output logic        illegal_instr,
`endif
  output logic        bus_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_bus_err;
  logic             w_wait;
  logic             w_timeout;
  iclass_t          w_class;
  logic             w_legal;
  logic             w_unused_bits;

  assign w_unused_bits = ^instr[31:12];
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign bus_err       = r_bus_err;

  opcode_decoder u_dec (
    .opcode (instr[6:0]),
    .iclass (w_class),
    .legal  (w_legal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait      = 1'b0;
    w_timeout   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        // ir_we is gated so the asynchronous reset window shows clean reset values
        if (mem_ready) begin
          ir_we       = ~rst;
          w_state_nxt = ST_DECODE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          w_wait = 1'b1;
        end
      end
      ST_DECODE: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        w_state_nxt = w_legal ? ST_EXEC : ST_HALT;
`else
        w_state_nxt = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        alu_a_sel = (w_class == CL_AUIPC) || (w_class == CL_BRANCH) || (w_class == CL_JAL);
        alu_b_sel = w_legal && uses_imm(w_class);
        if (!w_legal) begin
          pc_we       = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          case (w_class)
            CL_LOAD, CL_STORE: w_state_nxt = ST_MEM;
            CL_BRANCH: begin
              pc_we       = 1'b1;
              pc_sel      = br_taken ? PC_IMM : PC_PLUS4;
              w_state_nxt = ST_FETCH;
            end
            default:           w_state_nxt = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_class == CL_STORE);
        if (mem_ready) begin
          if (w_class == CL_STORE) begin
            pc_we       = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          w_wait = 1'b1;
        end
      end
      ST_WB: begin
        rf_we = (instr[11:7] != 5'd0);
        pc_we = 1'b1;
        case (w_class)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          CL_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_RS1_IMM;
          end
          CL_LUI:  wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
        w_state_nxt = ST_FETCH;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // Counter only survives a cycle that stays in the same waiting state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_wait ? w_cnt_inc : '0;
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign illegal_instr = r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (r_state == ST_DECODE && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Self-checking bench for multicycle_ctrl with a per-instruction model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, bus_err;
  logic [1:0]  pc_sel, wb_sel;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .bus_err   (bus_err)
  );

  typedef struct {
    int         cycles;
    int         n_req;
    int         n_we;
    int         n_rf;
    int         n_ir;
    int         bad;
    logic       a;
    logic       b;
    logic [1:0] psel;
    logic [1:0] wsel;
    logic       done;
  } rec_t;

  // Per-instruction expectation from the architectural rules, not the state machine.
  function automatic rec_t model(input logic [31:0] ins, input logic bt, input int df, input int dm);
    rec_t e;
    logic [6:0] opc;
    logic is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_rr, legal, wbpath;
    opc      = ins[6:0];
    is_ld    = (opc == 7'h03);
    is_st    = (opc == 7'h23);
    is_br    = (opc == 7'h63);
    is_jal   = (opc == 7'h6F);
    is_jalr  = (opc == 7'h67);
    is_lui   = (opc == 7'h37);
    is_auipc = (opc == 7'h17);
    is_rr    = (opc == 7'h33) || (opc == 7'h3B);
    legal    = is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc || is_rr ||
               (opc == 7'h13) || (opc == 7'h1B);
    wbpath   = legal && !is_st && !is_br;
    e.cycles = df + 1 + 2 + ((is_ld || is_st) ? dm + 1 : 0) + (wbpath ? 1 : 0);
    e.n_req  = df + 1 + ((is_ld || is_st) ? dm + 1 : 0);
    e.n_we   = is_st ? dm + 1 : 0;
    e.n_rf   = (wbpath && ins[11:7] != 5'd0) ? 1 : 0;
    e.n_ir   = 1;
    e.bad    = 0;
    e.a      = is_auipc || is_br || is_jal;
    e.b      = legal && !is_rr && !is_br;
    e.psel   = ((is_br && bt) || is_jal) ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
    e.wsel   = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
    e.done   = 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Acts as the memory: answers the fetch after df wait cycles and data after dm.
  task automatic run_instr(input logic [31:0] ins, input logic bt, input int df, input int dm,
                           output rec_t o);
    int run = 0;
    int w = 0;
    logic prev_req = 1'b0;
    o = '{default: 0};
    instr    = ins;
    br_taken = bt;
    while (!o.done && o.cycles < 40) begin
      @(negedge clk);
      if (mem_req) begin
        if (!prev_req) begin
          run++;
          w = 0;
        end else begin
          w++;
        end
      end
      prev_req  = mem_req;
      mem_ready = mem_req && (w == ((run == 1) ? df : dm));
      #1;
      o.cycles++;
      if (mem_req) o.n_req++;
      if (mem_we) o.n_we++;
      if (mem_we && !mem_req) o.bad++;
      if (rf_we) o.n_rf++;
      if (ir_we) o.n_ir++;
      o.a = o.a | alu_a_sel;
      o.b = o.b | alu_b_sel;
      if (pc_we) begin
        o.done = 1'b1;
        o.psel = pc_sel;
        o.wsel = wb_sel;
      end
    end
    n_tests++;
    if (!o.done) begin
      n_fail++;
      $display("FAIL instr_complete: no pc_we within 40 cycles for instr=%08h", ins);
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mem_req: got %b expected 1", mem_req);
    end
    n_tests++;
    if ({mem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel, bus_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {mem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel, bus_err});
    end
    do_reset();
  endtask

  task automatic test_addi();
    rec_t o;
    do_reset();
    run_instr(32'h00500093, 1'b0, 0, 0, o);
    n_tests++;
    if (o.cycles !== 4 || o.n_rf !== 1 || o.wsel !== 2'd0 || o.b !== 1'b1 || o.psel !== 2'd0) begin
      n_fail++;
      $display("FAIL addi: got cyc=%0d rf=%0d wb=%0d b=%b ps=%0d expected cyc=4 rf=1 wb=0 b=1 ps=0",
               o.cycles, o.n_rf, o.wsel, o.b, o.psel);
    end
  endtask

  task automatic test_branch();
    rec_t o;
    for (int t = 0; t < 2; t++) begin
      run_instr(32'h00000463, t[0], 0, 0, o);
      n_tests++;
      if (o.cycles !== 3 || o.n_rf !== 0 || o.psel !== {1'b0, t[0]} || o.a !== 1'b1) begin
        n_fail++;
        $display("FAIL beq_taken%0d: got cyc=%0d rf=%0d ps=%0d a=%b expected cyc=3 rf=0 ps=%0d a=1",
                 t, o.cycles, o.n_rf, o.psel, o.a, t);
      end
    end
  endtask

  task automatic test_store_delay();
    rec_t o;
    run_instr(32'h00113023, 1'b0, 0, 3, o);
    n_tests++;
    if (o.cycles !== 7 || o.n_we !== 4 || o.n_req !== 5 || o.n_rf !== 0 || o.bad !== 0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sd_delay: got cyc=%0d we=%0d req=%0d rf=%0d bad=%0d err=%b expected 7 4 5 0 0 0",
               o.cycles, o.n_we, o.n_req, o.n_rf, o.bad, bus_err);
    end
  endtask

  task automatic test_load_jalr();
    rec_t o;
    run_instr(32'h00013003, 1'b0, 1, 1, o);
    n_tests++;
    if (o.cycles !== 7 || o.n_rf !== 0 || o.wsel !== 2'd1 || o.n_req !== 4) begin
      n_fail++;
      $display("FAIL ld_x0: got cyc=%0d rf=%0d wb=%0d req=%0d expected 7 0 1 4",
               o.cycles, o.n_rf, o.wsel, o.n_req);
    end
    run_instr(32'h000100E7, 1'b0, 0, 0, o);
    n_tests++;
    if (o.cycles !== 4 || o.n_rf !== 1 || o.wsel !== 2'd2 || o.psel !== 2'd2) begin
      n_fail++;
      $display("FAIL jalr_x1: got cyc=%0d rf=%0d wb=%0d ps=%0d expected 4 1 2 2",
               o.cycles, o.n_rf, o.wsel, o.psel);
    end
  endtask

  task automatic test_timeout();
    rec_t o;
    int n_req = 0;
    int n_en = 0;
    do_reset();
    instr = 32'h00500093;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) begin
        n_tests++;
        if (bus_err !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_early_err: got %b expected 0", bus_err);
        end
      end
      if (mem_req) n_req++;
      if (pc_we || ir_we || rf_we) n_en++;
    end
    n_tests++;
    if (n_req !== TO || bus_err !== 1'b1 || mem_req !== 1'b0 || n_en !== 0) begin
      n_fail++;
      $display("FAIL timeout: got req_cycles=%0d err=%b req=%b en=%0d expected %0d 1 0 0",
               n_req, bus_err, mem_req, n_en, TO);
    end
    // Ready arriving on the last permitted wait cycle must still be honoured.
    do_reset();
    run_instr(32'h00500093, 1'b0, TO - 1, 0, o);
    n_tests++;
    if (o.cycles !== TO + 3 || bus_err !== 1'b0 || o.n_rf !== 1) begin
      n_fail++;
      $display("FAIL timeout_edge: got cyc=%0d err=%b rf=%0d expected %0d 0 1",
               o.cycles, bus_err, o.n_rf, TO + 3);
    end
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    int n_en = 0;
    do_reset();
    instr = 32'h0000007F;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = (c == 0);
      #1;
      if (pc_we || rf_we) n_en++;
    end
    mem_ready = 1'b0;
    n_tests++;
    if (illegal_instr !== 1'b1 || mem_req !== 1'b0 || n_en !== 0) begin
      n_fail++;
      $display("FAIL illegal_trap: got ill=%b req=%b en=%0d expected 1 0 0", illegal_instr, mem_req, n_en);
    end
    do_reset();
    n_tests++;
    if (illegal_instr !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got %b expected 0", illegal_instr);
    end
`else
    rec_t o;
    do_reset();
    run_instr(32'h0000007F, 1'b0, 0, 0, o);
    n_tests++;
    if (o.cycles !== 3 || o.psel !== 2'd0 || o.n_rf !== 0 || o.n_req !== 1) begin
      n_fail++;
      $display("FAIL illegal_nop: got cyc=%0d ps=%0d rf=%0d req=%0d expected 3 0 0 1",
               o.cycles, o.psel, o.n_rf, o.n_req);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    do_reset();
    instr = 32'h00113023;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      mem_ready = (c == 0);
      #1;
      seen = mem_we;
    end
    mem_ready = 1'b0;
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL async_reach_mem: got mem_we=0 expected 1");
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0 || ir_we !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b we=%b pc=%b rf=%b ir=%b expected 1 0 0 0 0",
               mem_req, mem_we, pc_we, rf_we, ir_we);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] opcs [0:11] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h03, 7'h23,
                                7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    rec_t o;
    rec_t e;
    int   n_op;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    n_op = 11;
`else
    n_op = 12;
`endif
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      logic        bt;
      int          df, dm;
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, n_op - 1)];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      bt = 1'($urandom_range(0, 1));
      df = $urandom_range(0, TO - 1);
      dm = $urandom_range(0, TO - 1);
      e  = model(ins, bt, df, dm);
      run_instr(ins, bt, df, dm, o);
      n_tests++;
      if (o.cycles !== e.cycles || o.n_req !== e.n_req || o.n_we !== e.n_we || o.n_ir !== e.n_ir ||
          o.bad !== 0) begin
        n_fail++;
        $display("FAIL rand_timing %08h: got cyc=%0d req=%0d we=%0d ir=%0d bad=%0d expected %0d %0d %0d %0d 0",
                 ins, o.cycles, o.n_req, o.n_we, o.n_ir, o.bad, e.cycles, e.n_req, e.n_we, e.n_ir);
      end
      n_tests++;
      if (o.n_rf !== e.n_rf || o.psel !== e.psel || o.wsel !== e.wsel) begin
        n_fail++;
        $display("FAIL rand_wb %08h bt=%b: got rf=%0d ps=%0d wb=%0d expected %0d %0d %0d",
                 ins, bt, o.n_rf, o.psel, o.wsel, e.n_rf, e.psel, e.wsel);
      end
      n_tests++;
      if (o.a !== e.a || o.b !== e.b || bus_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_alu %08h: got a=%b b=%b err=%b expected %b %b 0",
                 ins, o.a, o.b, bus_err, e.a, e.b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_store_delay();
    test_load_jalr();
    test_timeout();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV64I core. Sequences fetch, decode, execute, memory and writeback over one shared memory port.
- Consumes the latched instruction from the IR and the ALU branch flag. Drives all datapath enables and mux selects: PC, IR, register file, ALU operand muxes, writeback mux and data-memory handshake.
- The immediate generator stays combinational on the IR; this block only sequences around it.

Parameters:
- TIMEOUT, 255, max cycles waiting on mem_ready before a bus error (≥1).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- instr  in  32  IR contents (valid from DECODE onward)
- br_taken  in  1  ALU compare result for the current branch
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  store request (only with mem_req in MEM state)
- ir_we  out  1  latch fetched word into IR
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=PC+imm (branch/JAL), 2=rs1+imm (JALR)
- alu_a_sel  out  1  0=rs1, 1=PC
- alu_b_sel  out  1  0=rs2, 1=imm
- rf_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=mem data, 2=PC+4, 3=imm
- bus_err  out  1  sticky timeout flag

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is a package enum.
- Reset: async to FETCH. Wait counter cleared, bus_err=0. All outputs 0 except mem_req=1, which is combinational from FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1 and go to DECODE. Otherwise stay and increment the counter.
- DECODE: one cycle, always goes to EXEC. Opcode is classified from instr[6:0]: OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Anything else is illegal.
- EXEC operand selects:
  - alu_b_sel=1 for every immediate class.
  - alu_a_sel=1 for AUIPC, BRANCH and JAL.
- EXEC transitions:
  - LOAD/STORE go to MEM.
  - BRANCH: pc_we=1 with pc_sel=1 if br_taken, else pc_sel=0; then FETCH.
  - Every other legal class goes to WB.
- MEM: mem_req=1; mem_we=1 for STORE. On mem_ready:
  - STORE: pc_we=1, pc_sel=0, then FETCH.
  - LOAD: go to WB.
  - Otherwise hold and count.
- WB:
  - rf_we=1, except when instr[11:7]==0, where rf_we=0.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_we=1; pc_sel is 1 for JAL, 2 for JALR, else 0.
  - Then FETCH.
- Wait counter:
  - Counts consecutive non-ready cycles in FETCH/MEM and clears on any state change.
  - When the count reaches TIMEOUT without mem_ready: bus_err=1 and go to HALT.
  - mem_ready on the TIMEOUT cycle itself wins; no error.
- HALT: all enables 0, terminal until rst.
- Enables are single-cycle pulses.
- mem_req drops in the cycle after mem_ready and never toggles mid-wait.
- Reset during any wait aborts the request immediately, with no PC/RF side effects.

Optional Feature:
- Macro MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT and raises an extra output port illegal_instr. It is 1 bit, sticky, and cleared only by rst.
- Undefined: the port is absent, and an illegal opcode executes as a NOP. EXEC asserts pc_we with pc_sel=0 and returns to FETCH, with no rf_we.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum
  - opcode localparams
  - pc_sel and wb_sel encodings as typed enums
  - an instruction-class enum
- One sub-module, opcode_decoder: purely combinational, instr[6:0] → class plus legal bit. It is shared later with a pipelined core.
- The FSM and counter stay in multicycle_ctrl.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready on 1st FETCH cycle → FETCH, DECODE, EXEC, WB. Exactly 4 cycles, one rf_we with wb_sel=0 and alu_b_sel=1, one pc_we with pc_sel=0.
- BEQ with br_taken=1 → pc_we in EXEC with pc_sel=1, rf_we never asserted, 3 cycles. Repeat with br_taken=0 → pc_sel=0.
- SD (0x00113023) with mem_ready delayed 3 cycles in MEM → mem_req and mem_we held stable 4 cycles, pc_we one pulse, no rf_we.
- LD to rd=x0 → full 5-state path with rf_we=0 in WB. JALR to rd=x1 → wb_sel=2, pc_sel=2.
- TIMEOUT=4 with mem_ready stuck at 0 in FETCH → bus_err rises after 4 wait cycles, state HALT, mem_req=0. mem_ready on cycle 4 instead → no error.
- Opcode 0x7F: with the macro → illegal_instr=1 and HALT. Without → pc_we with pc_sel=0 and back to FETCH. Async rst asserted mid-MEM → outputs at reset values in the same cycle.
